// File: rtl/tff_bank_ctrl.sv
// Command sequencer for an external bank of T flip-flops.
// Drives per-bit toggles and checks the bank against the target.
module tff_bank_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [WIDTH-1:0] q_in,
   output logic [WIDTH-1:0] t_out,
   output logic             busy,
   output logic             done,
   output logic             err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_RUN,
      S_CHECK,
      S_DONE
   } state_t;

   localparam logic [1:0] OP_CLR = 2'b00;
   localparam logic [1:0] OP_LD  = 2'b01;
   localparam logic [1:0] OP_UP  = 2'b10;
   localparam logic [1:0] OP_DN  = 2'b11;

   state_t           r_state;
   logic [1:0]       r_op;
   logic [WIDTH-1:0] r_target;
   logic [WIDTH-1:0] r_rem;
   logic             r_err;

   logic [WIDTH-1:0] w_up;
   logic [WIDTH-1:0] w_dn;
   logic [WIDTH-1:0] w_t;
   logic             w_all1;
   logic             w_all0;

   // Sequencer: accept, apply/run, check, done pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_op     <= OP_CLR;
         r_target <= '0;
         r_rem    <= '0;
         r_err    <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_op  <= cmd_op;
                  r_err <= 1'b0;
                  r_rem <= '0;
                  unique case (cmd_op)
                     OP_CLR: begin
                        r_target <= '0;
                        r_state  <= S_APPLY;
                     end
                     OP_LD: begin
                        r_target <= cmd_data;
                        r_state  <= S_APPLY;
                     end
                     OP_UP: begin
                        r_target <= q_in + cmd_data;
                        r_rem    <= cmd_data;
                        r_state  <= (cmd_data != '0) ? S_RUN : S_CHECK;
                     end
                     OP_DN: begin
                        r_target <= q_in - cmd_data;
                        r_rem    <= cmd_data;
                        r_state  <= (cmd_data != '0) ? S_RUN : S_CHECK;
                     end
                     default: r_state <= S_IDLE;
                  endcase
               end
            end
            S_APPLY: r_state <= S_CHECK;
            S_RUN: begin
               r_rem <= r_rem - WIDTH'(1);
               if (r_rem == WIDTH'(1)) begin
                  r_state <= S_CHECK;
               end
            end
            S_CHECK: begin
               r_err   <= (q_in != r_target);
               r_state <= S_DONE;
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Toggle vector: diff mask in APPLY, counter carry/borrow chain in RUN.
   always_comb begin
      w_up   = '0;
      w_dn   = '0;
      w_t    = '0;
      w_all1 = 1'b1;
      w_all0 = 1'b1;
      for (int i = 0; i < WIDTH; i++) begin
         w_up[i] = w_all1;
         w_dn[i] = w_all0;
         w_all1  = w_all1 & q_in[i];
         w_all0  = w_all0 & ~q_in[i];
      end
      unique case (r_state)
         S_APPLY: w_t = q_in ^ r_target;
         S_RUN:   w_t = (r_op == OP_UP) ? w_up : w_dn;
         default: w_t = '0;
      endcase
   end

   assign t_out     = w_t;
   assign busy      = (r_state != S_IDLE);
   assign cmd_ready = (r_state == S_IDLE);
   assign done      = (r_state == S_DONE);
   assign err       = r_err;

endmodule
